// File: rtl/rc_scheduler.sv
// -----------------------------------------------------------------------------
// rc_scheduler
//
// Shares one combinational rc_unit route-computation datapath among the
// virtual channels of an input port. Each VC runs a small IDLE/WAIT/ROUTED
// state machine. A round-robin arbiter grants at most one waiting VC per
// cycle. The granted VC's head destination goes to the shared rc_unit, and
// the returned port is captured into that VC's route register. The route is
// held until the packet's tail flit leaves.
//
// Optional feature (compile-time macro RC_SCHED_STALL_CNT_EN):
//   When defined, adds stall_cnt_o. This is a 16-bit saturating count of
//   cycles in which more than one VC was requesting, so at least one lost
//   arbitration.
//
// Ports:
//   clk            in   clock; all state updates on the rising edge
//   rst            in   synchronous active-high reset
//   head_valid_i   in   [VC_NUM]   head flit present at front of VC v
//   x_dest_i       in   packed per-VC X destination (VC v in slice v)
//   y_dest_i       in   packed per-VC Y destination
//   l_dest_i       in   packed per-VC local (DLA) destination
//   release_i      in   [VC_NUM]   tail flit of VC v departed this cycle
//   rc_x_dest_o    out  granted VC's X destination to the shared rc_unit
//   rc_y_dest_o    out  granted VC's Y destination to the shared rc_unit
//   rc_l_dest_o    out  granted VC's local destination to the shared rc_unit
//   rc_out_port_i  in   combinational route returned by the shared rc_unit
//   route_valid_o  out  [VC_NUM]   VC v holds a valid route
//   out_port_o     out  [VC_NUM] x port_t registered route per VC
//   stall_cnt_o    out  16-bit stall counter (only with RC_SCHED_STALL_CNT_EN)
// -----------------------------------------------------------------------------

package rc_pkg;

    // Output-port encoding shared with rc_unit; all-zero means "no route".
    typedef logic [3:0] port_t;

    localparam port_t PORT_NONE = 4'd0;
    localparam port_t EAST      = 4'd1;
    localparam port_t WEST      = 4'd2;
    localparam port_t NORTH     = 4'd3;
    localparam port_t SOUTH     = 4'd4;
    localparam port_t DLA0      = 4'd5;
    localparam port_t DLA1      = 4'd6;
    localparam port_t DLA2      = 4'd7;
    localparam port_t DLA3      = 4'd8;

endpackage

module rc_scheduler
    import rc_pkg::*;
#(
    parameter int VC_NUM           = 4,
    parameter int DEST_ADDR_SIZE_X = 4,
    parameter int DEST_ADDR_SIZE_Y = 4,
    parameter int DEST_ADDR_SIZE_L = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [VC_NUM-1:0]                  head_valid_i,
    input  logic [VC_NUM*DEST_ADDR_SIZE_X-1:0] x_dest_i,
    input  logic [VC_NUM*DEST_ADDR_SIZE_Y-1:0] y_dest_i,
    input  logic [VC_NUM*DEST_ADDR_SIZE_L-1:0] l_dest_i,
    input  logic [VC_NUM-1:0]                  release_i,
    output logic [DEST_ADDR_SIZE_X-1:0]        rc_x_dest_o,
    output logic [DEST_ADDR_SIZE_Y-1:0]        rc_y_dest_o,
    output logic [DEST_ADDR_SIZE_L-1:0]        rc_l_dest_o,
    input  port_t                              rc_out_port_i,
    output logic [VC_NUM-1:0]                  route_valid_o,
    output port_t [VC_NUM-1:0]                 out_port_o
`ifdef RC_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]                        stall_cnt_o
`endif
);

    localparam int PTR_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ROUTED = 2'd2
    } vc_state_t;

    vc_state_t          state_q [VC_NUM];
    logic [VC_NUM-1:0]  req;
    logic               grant_valid;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    int                 cand;

    // A VC competes for the RC unit only while waiting AND its head is still
    // present, so a withdrawn head never gets a grant even in its last WAIT
    // cycle. Route validity is a pure decode of the ROUTED state.
    always_comb begin
        req           = '0;
        route_valid_o = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            req[v]           = (state_q[v] == ST_WAIT) && head_valid_i[v];
            route_valid_o[v] = (state_q[v] == ST_ROUTED);
        end
    end

    // Round-robin search starting at rr_ptr and wrapping modulo VC_NUM; the
    // first requester found wins. cand never reaches VC_NUM because the
    // wrap is applied before indexing.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < VC_NUM; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= VC_NUM) begin
                cand = cand - VC_NUM;
            end
            if (!grant_valid && req[PTR_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

    // Pointer moves just past the winner so that winner becomes lowest
    // priority next cycle.
    always_comb begin
        rr_next = rr_ptr;
        if (grant_valid) begin
            rr_next = PTR_W'((int'(grant_idx) + 1) % VC_NUM);
        end
    end

    // Destination mux into the shared rc_unit. It is forced to zero with no
    // grant so the rc_unit inputs do not toggle on idle cycles.
    always_comb begin
        rc_x_dest_o = '0;
        rc_y_dest_o = '0;
        rc_l_dest_o = '0;
        if (grant_valid) begin
            rc_x_dest_o = x_dest_i[int'(grant_idx)*DEST_ADDR_SIZE_X +: DEST_ADDR_SIZE_X];
            rc_y_dest_o = y_dest_i[int'(grant_idx)*DEST_ADDR_SIZE_Y +: DEST_ADDR_SIZE_Y];
            rc_l_dest_o = l_dest_i[int'(grant_idx)*DEST_ADDR_SIZE_L +: DEST_ADDR_SIZE_L];
        end
    end

    // Per-VC state machines, route registers and arbiter pointer.
    // A ROUTED VC ignores head_valid_i and always passes through IDLE on
    // release, so a back-to-back head gets a fresh WAIT and a fresh
    // computation instead of reusing the stale route. out_port_o is not
    // cleared on release; only a new grant or reset changes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= ST_IDLE;
            end
            out_port_o <= '0;
            rr_ptr     <= '0;
        end else begin
            rr_ptr <= rr_next;
            for (int v = 0; v < VC_NUM; v++) begin
                case (state_q[v])
                    ST_IDLE: begin
                        if (head_valid_i[v]) begin
                            state_q[v] <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (grant_valid && (int'(grant_idx) == v)) begin
                            state_q[v]    <= ST_ROUTED;
                            out_port_o[v] <= rc_out_port_i;
                        end else if (!head_valid_i[v]) begin
                            state_q[v] <= ST_IDLE;
                        end
                    end
                    ST_ROUTED: begin
                        if (release_i[v]) begin
                            state_q[v] <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q[v] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef RC_SCHED_STALL_CNT_EN
    // More than one requester means somebody lost arbitration this cycle.
    // The counter saturates rather than wraps so a long-running congestion
    // figure never reads as small.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (($countones(req) > 1) && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rc_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rc_scheduler
//
// Directed testbench for rc_scheduler (VC_NUM = 4). A small XY rc_unit model
// sits at router coordinate (1,1) and answers the scheduler's RC requests.
// Each table row is driven on a falling edge and checked 1 ns later. The
// checked values are the arbitration mux output for that cycle and the
// route state left by the previous rising edge. A hand-written sequence then
// measures head-to-route latency.
// -----------------------------------------------------------------------------

module tb_rc_scheduler;

    import rc_pkg::*;

    localparam int VC_NUM = 4;
    localparam int NVEC   = 33;

    logic                 clk;
    logic                 rst;
    logic [VC_NUM-1:0]    head_valid;
    logic [15:0]          x_dest;
    logic [15:0]          y_dest;
    logic [7:0]           l_dest;
    logic [VC_NUM-1:0]    release_v;
    logic [3:0]           rc_x_dest;
    logic [3:0]           rc_y_dest;
    logic [1:0]           rc_l_dest;
    port_t                rc_out_port;
    logic [VC_NUM-1:0]    route_valid;
    port_t [VC_NUM-1:0]   out_port;
`ifdef RC_SCHED_STALL_CNT_EN
    logic [15:0]          stall_cnt;
`endif

    int n_checks;
    int n_fail;

    rc_scheduler #(
        .VC_NUM           (VC_NUM),
        .DEST_ADDR_SIZE_X (4),
        .DEST_ADDR_SIZE_Y (4),
        .DEST_ADDR_SIZE_L (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .head_valid_i  (head_valid),
        .x_dest_i      (x_dest),
        .y_dest_i      (y_dest),
        .l_dest_i      (l_dest),
        .release_i     (release_v),
        .rc_x_dest_o   (rc_x_dest),
        .rc_y_dest_o   (rc_y_dest),
        .rc_l_dest_o   (rc_l_dest),
        .rc_out_port_i (rc_out_port),
        .route_valid_o (route_valid),
        .out_port_o    (out_port)
`ifdef RC_SCHED_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // XY-routing rc_unit model for a router at (1,1): resolve X first, then
    // Y, else eject to the local DLA port selected by l.
    always_comb begin
        rc_out_port = PORT_NONE;
        if (rc_x_dest > 4'd1) begin
            rc_out_port = EAST;
        end else if (rc_x_dest < 4'd1) begin
            rc_out_port = WEST;
        end else if (rc_y_dest > 4'd1) begin
            rc_out_port = NORTH;
        end else if (rc_y_dest < 4'd1) begin
            rc_out_port = SOUTH;
        end else begin
            rc_out_port = port_t'(DLA0 + {2'b00, rc_l_dest});
        end
    end

    typedef struct {
        logic        rst;
        logic [3:0]  head;
        logic [3:0]  rel;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  l;
        logic [3:0]  exp_rv;
        logic [9:0]  exp_rc;
        logic [15:0] exp_op;
        logic [15:0] exp_stall;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic applyStimulus(input logic r, input logic [3:0] h, input logic [3:0] rl,
                                 input logic [15:0] x, input logic [15:0] y, input logic [7:0] l);
        rst        = r;
        head_valid = h;
        release_v  = rl;
        x_dest     = x;
        y_dest     = y;
        l_dest     = l;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s vec %0d: got %h, expected %h", name, idx, actual, expected);
        end
    endtask

    int   lat;
    logic seen;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Section 1: single VC0 head, x=2,y=1,l=0 -> EAST, then release.
        vecs[0]  = '{1'b0, 4'b0000, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0000, 10'd0,                 16'h0000, 16'd0};
        vecs[1]  = '{1'b0, 4'b0001, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0000, 10'd0,                 16'h0000, 16'd0};
        vecs[2]  = '{1'b0, 4'b0001, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0000, {4'd2, 4'd1, 2'd0},   16'h0000, 16'd0};
        vecs[3]  = '{1'b0, 4'b0001, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0001, 10'd0,                 16'h0001, 16'd0};
        vecs[4]  = '{1'b0, 4'b0000, 4'b0001, 16'h1102, 16'h0311, 8'h00, 4'b0001, 10'd0,                 16'h0001, 16'd0};
        vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0000, 10'd0,                 16'h0001, 16'd0};
        // Section 2: reset, then all four heads together -> grants 0,1,2,3.
        vecs[6]  = '{1'b1, 4'b0000, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0000, 10'd0,                 16'h0001, 16'd0};
        vecs[7]  = '{1'b0, 4'b1111, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0000, 10'd0,                 16'h0000, 16'd0};
        vecs[8]  = '{1'b0, 4'b1111, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0000, {4'd2, 4'd1, 2'd0},   16'h0000, 16'd0};
        vecs[9]  = '{1'b0, 4'b1111, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0001, {4'd0, 4'd1, 2'd0},   16'h0001, 16'd1};
        vecs[10] = '{1'b0, 4'b1111, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0011, {4'd1, 4'd3, 2'd0},   16'h0021, 16'd2};
        vecs[11] = '{1'b0, 4'b1111, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0111, {4'd1, 4'd0, 2'd0},   16'h0321, 16'd3};
        // Section 3: wrap-around after VC3 grant; VC0 and VC3 re-request.
        vecs[12] = '{1'b0, 4'b0000, 4'b1001, 16'h1102, 16'h0311, 8'h00, 4'b1111, 10'd0,                 16'h4321, 16'd3};
        vecs[13] = '{1'b0, 4'b1001, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0110, 10'd0,                 16'h4321, 16'd3};
        vecs[14] = '{1'b0, 4'b1001, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0110, {4'd2, 4'd1, 2'd0},   16'h4321, 16'd3};
        vecs[15] = '{1'b0, 4'b1001, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0111, {4'd1, 4'd0, 2'd0},   16'h4321, 16'd4};
        vecs[16] = '{1'b0, 4'b0000, 4'b1111, 16'h1102, 16'h0311, 8'h00, 4'b1111, 10'd0,                 16'h4321, 16'd4};
        // Section 4: VC1 withdraws its head before being granted.
        vecs[17] = '{1'b0, 4'b0010, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0000, 10'd0,                 16'h4321, 16'd4};
        vecs[18] = '{1'b0, 4'b0000, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0000, 10'd0,                 16'h4321, 16'd4};
        vecs[19] = '{1'b0, 4'b0000, 4'b0000, 16'h1102, 16'h0311, 8'h00, 4'b0000, 10'd0,                 16'h4321, 16'd4};
        // Section 5: VC2 routed WEST, then release with next head -> DLA3.
        vecs[20] = '{1'b0, 4'b0100, 4'b0000, 16'h1002, 16'h0111, 8'h00, 4'b0000, 10'd0,                 16'h4321, 16'd4};
        vecs[21] = '{1'b0, 4'b0100, 4'b0000, 16'h1002, 16'h0111, 8'h00, 4'b0000, {4'd0, 4'd1, 2'd0},   16'h4321, 16'd4};
        vecs[22] = '{1'b0, 4'b0100, 4'b0000, 16'h1002, 16'h0111, 8'h00, 4'b0100, 10'd0,                 16'h4221, 16'd4};
        vecs[23] = '{1'b0, 4'b0100, 4'b0100, 16'h1102, 16'h0111, 8'h30, 4'b0100, 10'd0,                 16'h4221, 16'd4};
        vecs[24] = '{1'b0, 4'b0100, 4'b0000, 16'h1102, 16'h0111, 8'h30, 4'b0000, 10'd0,                 16'h4221, 16'd4};
        vecs[25] = '{1'b0, 4'b0100, 4'b0000, 16'h1102, 16'h0111, 8'h30, 4'b0000, {4'd1, 4'd1, 2'd3},   16'h4221, 16'd4};
        // Section 6: reset with VC1 in WAIT and VC2/VC3 ROUTED.
        vecs[26] = '{1'b0, 4'b1010, 4'b0000, 16'h1102, 16'h0111, 8'h30, 4'b0100, 10'd0,                 16'h4821, 16'd4};
        vecs[27] = '{1'b0, 4'b1010, 4'b0000, 16'h1102, 16'h0111, 8'h30, 4'b0100, {4'd1, 4'd0, 2'd0},   16'h4821, 16'd4};
        vecs[28] = '{1'b1, 4'b1010, 4'b0000, 16'h1102, 16'h0111, 8'h30, 4'b1100, {4'd0, 4'd1, 2'd0},   16'h4821, 16'd5};
        vecs[29] = '{1'b0, 4'b0000, 4'b0000, 16'h1102, 16'h0111, 8'h30, 4'b0000, 10'd0,                 16'h0000, 16'd0};
        vecs[30] = '{1'b0, 4'b1111, 4'b0000, 16'h1102, 16'h0111, 8'h30, 4'b0000, 10'd0,                 16'h0000, 16'd0};
        vecs[31] = '{1'b0, 4'b1111, 4'b0000, 16'h1102, 16'h0111, 8'h30, 4'b0000, {4'd2, 4'd1, 2'd0},   16'h0000, 16'd0};
        vecs[32] = '{1'b0, 4'b0000, 4'b0000, 16'h1102, 16'h0111, 8'h30, 4'b0001, 10'd0,                 16'h0001, 16'd1};

        // Preamble: hold reset for two edges with quiet inputs.
        applyStimulus(1'b1, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 8'h00);
        repeat (2) @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].rst, vecs[i].head, vecs[i].rel, vecs[i].x, vecs[i].y, vecs[i].l);
            #1;
            checkOutput("route_valid", i, 32'(route_valid), 32'(vecs[i].exp_rv));
            checkOutput("rc_dest", i, 32'({rc_x_dest, rc_y_dest, rc_l_dest}), 32'(vecs[i].exp_rc));
            checkOutput("out_port", i, 32'(out_port), 32'(vecs[i].exp_op));
`ifdef RC_SCHED_STALL_CNT_EN
            checkOutput("stall_cnt", i, 32'(stall_cnt), 32'(vecs[i].exp_stall));
`endif
        end

        // Latency: release VC0, let it settle in IDLE, then assert a new head
        // and count falling edges until route_valid[0] appears (expect 2).
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000, 4'b0001, 16'h1102, 16'h0111, 8'h30);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 16'h1102, 16'h0111, 8'h30);
        #1;
        checkOutput("released_rv", NVEC, 32'(route_valid), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0001, 4'b0000, 16'h1102, 16'h0111, 8'h30);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            #1;
            seen = route_valid[0];
        end
        checkOutput("latency", NVEC + 1, 32'(lat), 32'd2);
        checkOutput("latency_port", NVEC + 1, 32'(out_port[0]), 32'(EAST));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rc_scheduler.md
# rc_scheduler

Time-multiplexes one shared `rc_unit` route-computation datapath among the virtual channels (VCs) of an input port. It runs one per-VC state machine and a round-robin arbiter. Each cycle it drives the granted VC's destination into the shared `rc_unit` and registers the returned `port_t` into that VC's route register. The registered route is held until the packet's tail flit leaves. It sits between the input-port VC buffers and the VC/switch allocators.

## Interface
- `VC_NUM`, 4: number of VCs sharing the RC unit, range 2..8.
- `DEST_ADDR_SIZE_X`, 4: X destination width.
- `DEST_ADDR_SIZE_Y`, 4: Y destination width.
- `DEST_ADDR_SIZE_L`, 2: local (DLA) destination width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `head_valid_i`  in  `VC_NUM`  head flit at the front of VC *v*.
- `x_dest_i`  in  `VC_NUM*DEST_ADDR_SIZE_X`  packed head X destination per VC; VC *v* occupies slice *v*.
- `y_dest_i`  in  `VC_NUM*DEST_ADDR_SIZE_Y`  packed head Y destination per VC.
- `l_dest_i`  in  `VC_NUM*DEST_ADDR_SIZE_L`  packed head local destination per VC.
- `release_i`  in  `VC_NUM`  tail flit of VC *v* departed this cycle.
- `rc_x_dest_o`  out  `DEST_ADDR_SIZE_X`  to the shared `rc_unit` `x_dest_i`.
- `rc_y_dest_o`  out  `DEST_ADDR_SIZE_Y`  to the shared `rc_unit` `y_dest_i`.
- `rc_l_dest_o`  out  `DEST_ADDR_SIZE_L`  to the shared `rc_unit` `l_dest_i`.
- `rc_out_port_i`  in  `port_t`  combinational result from the shared `rc_unit`.
- `route_valid_o`  out  `VC_NUM`  VC *v* holds a valid route.
- `out_port_o`  out  `VC_NUM` x `port_t`  registered route per VC.
- `stall_cnt_o`  out  16  arbitration stall counter; present only with `RC_SCHED_STALL_CNT_EN`.

## Operation
- **Per-VC FSM states:** IDLE, WAIT, ROUTED.
  - IDLE to WAIT when `head_valid_i[v]` is 1.
  - WAIT to ROUTED on the edge ending a cycle in which VC *v* is granted. The same edge loads `out_port_o[v]` with `rc_out_port_i`.
  - WAIT to IDLE if `head_valid_i[v]` drops before grant (request withdrawn). No route is written.
  - ROUTED to IDLE when `release_i[v]` is 1. `head_valid_i[v]` is ignored while in ROUTED.
- **Request vector:** `req[v]` = (state == WAIT) & `head_valid_i[v]`.
- **Arbiter:** round-robin, one grant per cycle.
  - The search starts at pointer `rr_ptr` and wraps modulo `VC_NUM`.
  - On a grant to VC *g*, `rr_ptr` becomes (*g*+1) mod `VC_NUM`.
  - `rr_ptr` is unchanged when there is no grant.
- **RC mux:** `rc_*_dest_o` carry the granted VC's destination slice. They are all-zero when there is no grant.
- **Route outputs:** `route_valid_o[v]` = (state == ROUTED). `out_port_o[v]` holds its value until the next ROUTED entry; it is not cleared on release.
- **Ignored release:** `release_i[v]` in IDLE or WAIT has no effect.
- **Release and head in the same cycle** (ROUTED, next head already present): the VC goes to IDLE. It enters WAIT on the next edge and requests one cycle later. It can never reuse the stale route.
- **Reset:** every VC to IDLE, `route_valid_o` = 0, every `out_port_o` = 0 (all-zero encoding), `rr_ptr` = 0, `stall_cnt_o` = 0.
- **Reset mid-operation:** in-flight WAIT and ROUTED state is discarded. Routes are recomputed after reset deasserts.

## Timing
- **Minimum latency:** head asserted in cycle *n*, then WAIT at edge *n*+1, grant in cycle *n*+1, `route_valid_o` high after edge *n*+2.
- **Throughput:** one route per cycle across all VCs.
- **Worst-case wait:** `VC_NUM`-1 grant cycles after entering WAIT.
- **Shared `rc_unit` path:** purely combinational. The timing path is the grant mux, then `rc_unit`, then the route register.
- **Release:** `route_valid_o[v]` falls the edge after `release_i[v]`.

## Configuration
- **`RC_SCHED_STALL_CNT_EN` defined:**
  - `stall_cnt_o` is present. It is a 16-bit saturating counter.
  - It increments on each cycle in which at least one `req[v]` is set and not granted (i.e. popcount(`req`) > 1). It holds at 16'hFFFF.
  - It is cleared only by `rst`.
- **`RC_SCHED_STALL_CNT_EN` undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan
- **Single VC.** Stimulus: `rst`, then VC0 head with x=2, y=1, l=0, and `rc_unit` at (1,1). Required: `route_valid_o[0]` rises 2 cycles after head, and `out_port_o[0]` = EAST.
- **All VCs request in the same cycle.** Stimulus: `VC_NUM`=4, `rr_ptr`=0, all four heads asserted together. Required: grants in order 0,1,2,3 on consecutive cycles. With the macro, `stall_cnt_o` = 3 after the sequence (3+2+1 is not counted; only cycles with a loser count: 3 cycles).
- **Wrap-around.** Stimulus: grant VC3, then requests from VC0 and VC3. Required: VC0 granted first.
- **Withdraw.** Stimulus: VC1 enters WAIT and `head_valid_i[1]` drops before grant. Required: VC1 returns to IDLE, `out_port_o[1]` is unchanged, and no grant is issued to VC1.
- **Release with next head.** Stimulus: VC2 ROUTED to WEST, then `release_i[2]` asserted with a new head for x=current, y=current, l=3. Required: `route_valid_o[2]` is low for at least 2 cycles, then the route becomes DLA3.
- **Reset mid-operation.** Stimulus: `rst` asserted with VCs in WAIT and ROUTED. Required: the next cycle shows all `route_valid_o` = 0, `out_port_o` = 0, and the arbiter restarting from VC0.
